// File: rtl/param_blackjack_pkg.sv
// Shared types and card arithmetic for the parametrised blackjack controller.
package param_blackjack_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEAL,
        PLAYER,
        DEALER,
        RESULT
    } state_t;

    localparam logic [3:0] ACE_RANK   = 4'd1;
    localparam logic [3:0] FACE_VALUE = 4'd10;

    // Faces and any out-of-range rank (0, 14, 15) count as ten.
    function automatic logic [3:0] rank_value(input logic [3:0] rank);
        if (rank == 4'd0 || rank > 4'd10)
            return FACE_VALUE;
        return rank;
    endfunction

    function automatic int best_sum(input int hard, input logic ace,
                                    input int target);
        if (ace && (hard + 10 <= target))
            return hard + 10;
        return hard;
    endfunction

endpackage

// File: rtl/bj_card_src.sv
// Card source: free-running LFSR folded to ranks 1..13, or an external feed.
module bj_card_src
    import param_blackjack_pkg::*;
#(
    parameter bit          EXT_CARDS = 1'b0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       clk,
    input  logic       res,
    input  logic [3:0] card_in,
    input  logic       card_vld,
    output logic [3:0] card_rank,
    output logic       rank_vld
);

    if (LFSR_SEED == 16'h0) begin : g_bad_seed
        $error("LFSR_SEED must be nonzero");
    end

    logic [15:0] lfsr;
    logic [3:0]  raw;
    logic [3:0]  folded;
    logic [3:0]  lfsr_rank;

    always_ff @(posedge clk) begin
        if (res)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    assign raw       = lfsr[3:0];
    assign folded    = (raw >= 4'd13) ? raw - 4'd13 : raw;
    assign lfsr_rank = folded + 4'd1;

    assign card_rank = EXT_CARDS ? card_in : lfsr_rank;
    assign rank_vld  = EXT_CARDS ? card_vld : 1'b1;

endmodule

// File: rtl/param_blackjack.sv
// Player-versus-dealer round controller with soft-ace tracking and naturals.
module param_blackjack
    import param_blackjack_pkg::*;
#(
    parameter int          TARGET          = 21,
    parameter int          DEALER_STAND    = 17,
    parameter bit          DEALER_HIT_SOFT = 1'b0,
    parameter int          SUM_W           = 6,
    parameter bit          EXT_CARDS       = 1'b0,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic             clk,
    input  logic             res,
    input  logic             start,
    input  logic             hit,
    input  logic             stand,
    input  logic [3:0]       card_in,
    input  logic             card_vld,
    output logic             card_req,
    output logic [SUM_W-1:0] p_c,
    output logic [SUM_W-1:0] d_c,
    output logic             win,
    output logic             lose,
    output logic             tie,
    output logic             bj,
    output logic             busy
);

    if (2 ** SUM_W <= TARGET + 11) begin : g_bad_width
        $error("SUM_W too narrow for TARGET");
    end

    logic [3:0] card_rank;
    logic       rank_vld;

    bj_card_src #(
        .EXT_CARDS(EXT_CARDS),
        .LFSR_SEED(LFSR_SEED)
    ) u_src (
        .clk      (clk),
        .res      (res),
        .card_in  (card_in),
        .card_vld (card_vld),
        .card_rank(card_rank),
        .rank_vld (rank_vld)
    );

    state_t           state, state_n;
    logic [1:0]       deal_cnt, deal_cnt_n;
    logic [SUM_W-1:0] p_hard, p_hard_n, d_hard, d_hard_n;
    logic             p_ace, p_ace_n, d_ace, d_ace_n;
    logic             hit_pending, hit_pending_n;
    logic             start_q, hit_q, stand_q;
    logic [SUM_W-1:0] p_c_n, d_c_n;
    logic             win_n, lose_n, tie_n, bj_n, busy_n;

    logic             start_ev, hit_ev, stand_ev;
    logic [3:0]       card_val;
    logic             card_ace;
    logic [SUM_W-1:0] p_best, d_best;
    logic [SUM_W-1:0] p_add_hard, d_add_hard;
    logic [SUM_W-1:0] p_add_best, d_add_best;
    logic             p_add_ace, d_add_ace;
    logic             d_soft, dealer_draw, xfer;

    assign start_ev = start & ~start_q;
    assign hit_ev   = hit & ~hit_q;
    assign stand_ev = stand & ~stand_q;

    assign card_val   = rank_value(card_rank);
    assign card_ace   = (card_rank == ACE_RANK);
    assign p_add_hard = p_hard + SUM_W'(card_val);
    assign d_add_hard = d_hard + SUM_W'(card_val);
    assign p_add_ace  = p_ace | card_ace;
    assign d_add_ace  = d_ace | card_ace;

    assign p_best     = SUM_W'(best_sum(int'(p_hard), p_ace, TARGET));
    assign d_best     = SUM_W'(best_sum(int'(d_hard), d_ace, TARGET));
    assign p_add_best = SUM_W'(best_sum(int'(p_add_hard), p_add_ace, TARGET));
    assign d_add_best = SUM_W'(best_sum(int'(d_add_hard), d_add_ace, TARGET));

    assign d_soft      = d_ace && (int'(d_hard) + 10 <= TARGET);
    assign dealer_draw = (int'(d_best) < DEALER_STAND) ||
                         ((int'(d_best) == DEALER_STAND) && d_soft &&
                          DEALER_HIT_SOFT);

    always_comb begin
        card_req = 1'b0;
        unique case (state)
            DEAL:    card_req = 1'b1;
            PLAYER:  card_req = hit_pending;
            DEALER:  card_req = dealer_draw;
            default: card_req = 1'b0;
        endcase
    end

    assign xfer = card_req & rank_vld;

    always_comb begin
        state_n       = state;
        deal_cnt_n    = deal_cnt;
        p_hard_n      = p_hard;
        p_ace_n       = p_ace;
        d_hard_n      = d_hard;
        d_ace_n       = d_ace;
        hit_pending_n = hit_pending;
        p_c_n         = p_c;
        d_c_n         = d_c;
        win_n         = win;
        lose_n        = lose;
        tie_n         = tie;
        bj_n          = bj;
        busy_n        = busy;
        unique case (state)
            IDLE: begin
                if (start_ev) begin
                    p_hard_n      = '0;
                    p_ace_n       = 1'b0;
                    d_hard_n      = '0;
                    d_ace_n       = 1'b0;
                    p_c_n         = '0;
                    d_c_n         = '0;
                    {win_n, lose_n, tie_n, bj_n} = 4'b0000;
                    deal_cnt_n    = 2'd0;
                    hit_pending_n = 1'b0;
                    busy_n        = 1'b1;
                    state_n       = DEAL;
                end
            end
            DEAL: begin
                if (xfer) begin
                    deal_cnt_n = deal_cnt + 2'd1;
                    if (!deal_cnt[0]) begin
                        p_hard_n = p_add_hard;
                        p_ace_n  = p_add_ace;
                        p_c_n    = p_add_best;
                    end else begin
                        d_hard_n = d_add_hard;
                        d_ace_n  = d_add_ace;
                        d_c_n    = d_add_best;
                    end
                    // The last dealt card is the dealer's, so p_best is final.
                    if (deal_cnt == 2'd3) begin
                        bj_n    = (int'(p_best) == TARGET);
                        state_n = bj_n ? RESULT : PLAYER;
                    end
                end
            end
            PLAYER: begin
                if (hit_pending) begin
                    if (xfer) begin
                        p_hard_n      = p_add_hard;
                        p_ace_n       = p_add_ace;
                        p_c_n         = p_add_best;
                        hit_pending_n = 1'b0;
                        if (int'(p_add_hard) > TARGET)
                            state_n = RESULT;
                    end
                end else if (stand_ev) begin
                    state_n = DEALER;
                end else if (hit_ev) begin
                    hit_pending_n = 1'b1;
                end
            end
            DEALER: begin
                if (!dealer_draw) begin
                    state_n = RESULT;
                end else if (xfer) begin
                    d_hard_n = d_add_hard;
                    d_ace_n  = d_add_ace;
                    d_c_n    = d_add_best;
                end
            end
            RESULT: begin
                {win_n, lose_n, tie_n} = 3'b000;
                if (int'(p_hard) > TARGET)
                    lose_n = 1'b1;
                else if (bj)
                    if (int'(d_best) == TARGET) tie_n = 1'b1;
                    else                        win_n = 1'b1;
                else if (int'(d_hard) > TARGET)
                    win_n = 1'b1;
                else if (p_best > d_best)
                    win_n = 1'b1;
                else if (p_best < d_best)
                    lose_n = 1'b1;
                else
                    tie_n = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state       <= IDLE;
            deal_cnt    <= 2'd0;
            p_hard      <= '0;
            p_ace       <= 1'b0;
            d_hard      <= '0;
            d_ace       <= 1'b0;
            hit_pending <= 1'b0;
            start_q     <= 1'b0;
            hit_q       <= 1'b0;
            stand_q     <= 1'b0;
            p_c         <= '0;
            d_c         <= '0;
            win         <= 1'b0;
            lose        <= 1'b0;
            tie         <= 1'b0;
            bj          <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            deal_cnt    <= deal_cnt_n;
            p_hard      <= p_hard_n;
            p_ace       <= p_ace_n;
            d_hard      <= d_hard_n;
            d_ace       <= d_ace_n;
            hit_pending <= hit_pending_n;
            start_q     <= start;
            hit_q       <= hit;
            stand_q     <= stand;
            p_c         <= p_c_n;
            d_c         <= d_c_n;
            win         <= win_n;
            lose        <= lose_n;
            tie         <= tie_n;
            bj          <= bj_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_param_blackjack.sv
// Round-level bench: vector table of hands plus hand-written corner sequences.
module tb_param_blackjack;

    logic       clk = 1'b0;
    logic       res, start, hit, stand, card_vld;
    logic [3:0] card_in;
    logic       card_req, win, lose, tie, bj, busy;
    logic [5:0] p_c, d_c;

    always #5 clk = ~clk;

    param_blackjack #(.EXT_CARDS(1'b1)) dut (
        .clk     (clk),
        .res     (res),
        .start   (start),
        .hit     (hit),
        .stand   (stand),
        .card_in (card_in),
        .card_vld(card_vld),
        .card_req(card_req),
        .p_c     (p_c),
        .d_c     (d_c),
        .win     (win),
        .lose    (lose),
        .tie     (tie),
        .bj      (bj),
        .busy    (busy)
    );

    typedef struct packed {
        logic [5:0] p;
        logic [5:0] d;
        logic       w;
        logic       l;
        logic       t;
        logic       b;
    } exp_t;

    typedef struct {
        logic [0:3][3:0] deal;
        int              nh;
        logic [0:1][3:0] hits;
        logic [0:1][5:0] hp;
        bit              st;
        int              nd;
        logic [0:1][3:0] dc;
        logic [5:0]      p0;
        logic [5:0]      d0;
        exp_t            e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic exp_t mke(int p, int d, bit w, bit l, bit t, bit b);
        exp_t e;
        e.p = 6'(p);
        e.d = 6'(d);
        e.w = w;
        e.l = l;
        e.t = t;
        e.b = b;
        return e;
    endfunction

    function automatic vec_t mkv(logic [15:0] deal, int nh, logic [7:0] hits,
                                 logic [11:0] hp, bit st, int nd,
                                 logic [7:0] dc, int p0, int d0, exp_t e);
        vec_t v;
        v.deal = deal;
        v.nh   = nh;
        v.hits = hits;
        v.hp   = hp;
        v.st   = st;
        v.nd   = nd;
        v.dc   = dc;
        v.p0   = 6'(p0);
        v.d0   = 6'(d0);
        v.e    = e;
        return v;
    endfunction

    task automatic chk(string name, int act, int req);
        n_vec++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic do_start(input exp_t e);
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", int'(busy), 1);
        chk("start_clr", int'({win, lose, tie, bj}), 0);
    endtask

    task automatic do_hit();
        hit = 1'b1;
        @(negedge clk);
        hit = 1'b0;
    endtask

    task automatic do_stand();
        stand = 1'b1;
        @(negedge clk);
        stand = 1'b0;
    endtask

    task automatic feed(input logic [3:0] v);
        bit done;
        done     = 1'b0;
        card_in  = v;
        card_vld = 1'b1;
        for (int k = 0; k < 40 && !done; k++) begin
            if (card_req) done = 1'b1;
            @(negedge clk);
        end
        card_vld = 1'b0;
        if (!done) chk("feed_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int   reqs;
        bit   ok;
        exp_t e;
        reqs = 0;
        ok   = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            if (!busy) ok = 1'b1;
            else begin
                if (card_req) reqs++;
                @(negedge clk);
            end
        end
        chk("done_timeout", int'(ok), 1);
        chk("extra_card_req", reqs, 0);
        if (sb.size() == 0) begin
            chk("sb_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("p_c", int'(p_c), int'(e.p));
            chk("d_c", int'(d_c), int'(e.d));
            chk("win", int'(win), int'(e.w));
            chk("lose", int'(lose), int'(e.l));
            chk("tie", int'(tie), int'(e.t));
            chk("bj", int'(bj), int'(e.b));
        end
    endtask

    task automatic run_vec(input vec_t v);
        do_start(v.e);
        for (int j = 0; j < 4; j++) feed(v.deal[j]);
        chk("deal_p", int'(p_c), int'(v.p0));
        chk("deal_d", int'(d_c), int'(v.d0));
        for (int j = 0; j < v.nh; j++) begin
            do_hit();
            feed(v.hits[j]);
            chk("hit_p", int'(p_c), int'(v.hp[j]));
        end
        if (v.st) do_stand();
        for (int j = 0; j < v.nd; j++) feed(v.dc[j]);
        wait_done();
    endtask

    initial begin
        int   n;
        exp_t e;

        res      = 1'b1;
        start    = 1'b0;
        hit      = 1'b0;
        stand    = 1'b0;
        card_vld = 1'b0;
        card_in  = 4'd0;
        repeat (2) @(negedge clk);
        res = 1'b0;
        chk("rst_out", int'({p_c, d_c, win, lose, tie, bj, busy, card_req}), 0);

        vecs.push_back(mkv({4'd10, 4'd9, 4'd7, 4'd8}, 0, 8'h0, 12'h0, 1, 0,
                           8'h0, 17, 17, mke(17, 17, 0, 0, 1, 0)));
        vecs.push_back(mkv({4'd1, 4'd10, 4'd13, 4'd6}, 0, 8'h0, 12'h0, 0, 0,
                           8'h0, 21, 16, mke(21, 16, 1, 0, 0, 1)));
        vecs.push_back(mkv({4'd1, 4'd10, 4'd5, 4'd6}, 2, {4'd10, 4'd9},
                           {6'd16, 6'd25}, 0, 0, 8'h0, 16, 16,
                           mke(25, 16, 0, 1, 0, 0)));
        vecs.push_back(mkv({4'd10, 4'd10, 4'd8, 4'd6}, 0, 8'h0, 12'h0, 1, 1,
                           {4'd12, 4'd0}, 18, 16, mke(18, 26, 1, 0, 0, 0)));
        vecs.push_back(mkv({4'd10, 4'd10, 4'd9, 4'd7}, 0, 8'h0, 12'h0, 1, 0,
                           8'h0, 19, 17, mke(19, 17, 1, 0, 0, 0)));
        vecs.push_back(mkv({4'd10, 4'd10, 4'd7, 4'd9}, 0, 8'h0, 12'h0, 1, 0,
                           8'h0, 17, 19, mke(17, 19, 0, 1, 0, 0)));
        vecs.push_back(mkv({4'd1, 4'd1, 4'd10, 4'd10}, 0, 8'h0, 12'h0, 0, 0,
                           8'h0, 21, 21, mke(21, 21, 0, 0, 1, 1)));
        vecs.push_back(mkv({4'd10, 4'd1, 4'd7, 4'd6}, 0, 8'h0, 12'h0, 1, 0,
                           8'h0, 17, 17, mke(17, 17, 0, 0, 1, 0)));
        vecs.push_back(mkv({4'd10, 4'd5, 4'd9, 4'd1}, 0, 8'h0, 12'h0, 1, 1,
                           {4'd2, 4'd0}, 19, 16, mke(19, 18, 1, 0, 0, 0)));
        vecs.push_back(mkv({4'd0, 4'd10, 4'd15, 4'd7}, 0, 8'h0, 12'h0, 1, 0,
                           8'h0, 20, 17, mke(20, 17, 1, 0, 0, 0)));
        vecs.push_back(mkv({4'd5, 4'd10, 4'd6, 4'd7}, 1, {4'd10, 4'd0},
                           {6'd21, 6'd0}, 1, 0, 8'h0, 11, 17,
                           mke(21, 17, 1, 0, 0, 0)));

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset after two dealt cards, then a clean round from card one.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        feed(4'd10);
        feed(4'd9);
        res = 1'b1;
        repeat (2) @(negedge clk);
        res = 1'b0;
        chk("mid_rst_out",
            int'({p_c, d_c, win, lose, tie, bj, busy, card_req}), 0);
        run_vec(vecs[0]);

        // A hit level held for five cycles draws exactly one card.
        do_start(mke(14, 18, 0, 1, 0, 0));
        feed(4'd10); feed(4'd10); feed(4'd2); feed(4'd3);
        n        = 0;
        hit      = 1'b1;
        card_in  = 4'd2;
        card_vld = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (card_req) n++;
            @(negedge clk);
        end
        hit      = 1'b0;
        card_vld = 1'b0;
        chk("held_hit_cards", n, 1);
        chk("held_hit_p", int'(p_c), 14);
        do_stand();
        feed(4'd5);
        wait_done();

        // Hit and stand together, then a dealer stall with a stray start.
        e = mke(18, 21, 0, 1, 0, 0);
        do_start(e);
        feed(4'd10); feed(4'd10); feed(4'd8); feed(4'd6);
        hit   = 1'b1;
        stand = 1'b1;
        @(negedge clk);
        hit   = 1'b0;
        stand = 1'b0;
        for (int k = 0; k < 3; k++) begin
            start = (k == 1);
            chk("stall_req", int'(card_req), 1);
            chk("stall_d", int'(d_c), 16);
            chk("stall_busy", int'(busy), 1);
            @(negedge clk);
        end
        start = 1'b0;
        chk("stray_start_d", int'(d_c), 16);
        chk("hit_discarded", int'(p_c), 18);
        feed(4'd5);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "bench timeout");
    end

endmodule
